axi_lite_ctrl_regs: RTL and testbench

// - AXI4-Lite slave register file driving the control block's command inputs.
// - Supplies slave_lite_reg0..3 to the controller and returns controller status to the host.
// - Reports the FSM state and a sticky done flag, and self-clears the start bits on task_finish.
// - Sits between the PS AXI GP port and the accelerator's main control FSM.

---
 rtl/axi_lite_ctrl_regs.sv | 197 +++++++++++++++++++
 tb/tb_axi_lite_ctrl_regs.sv | 484 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_ctrl_regs.sv
// AXI4-Lite control/status register file for the accelerator's main control FSM.
// Optional macro CTRL_IRQ_EN adds the IRQ_MASK register at 0x14 and the irq output.
module axi_lite_ctrl_regs #(
    parameter int ADDR_W = 5
) (
    input  logic              sclk,
    input  logic              s_rst_n,
    input  logic [ADDR_W-1:0] s_axi_awaddr,
    input  logic              s_axi_awvalid,
    output logic              s_axi_awready,
    input  logic [31:0]       s_axi_wdata,
    input  logic [3:0]        s_axi_wstrb,
    input  logic              s_axi_wvalid,
    output logic              s_axi_wready,
    output logic [1:0]        s_axi_bresp,
    output logic              s_axi_bvalid,
    input  logic              s_axi_bready,
    input  logic [ADDR_W-1:0] s_axi_araddr,
    input  logic              s_axi_arvalid,
    output logic              s_axi_arready,
    output logic [31:0]       s_axi_rdata,
    output logic [1:0]        s_axi_rresp,
    output logic              s_axi_rvalid,
    input  logic              s_axi_rready,
    output logic [31:0]       slave_lite_reg0,
    output logic [31:0]       slave_lite_reg1,
    output logic [31:0]       slave_lite_reg2,
    output logic [31:0]       slave_lite_reg3,
    input  logic              task_finish,
    input  logic [5:0]        state
`ifdef CTRL_IRQ_EN
    ,
    output logic              irq
`endif
);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Handshake: a transfer happens on a rising edge where valid and ready are both 1;
    // the source holds valid and payload stable until then, ready never waits on valid.

    logic [31:0] regs [4];
    logic        aw_held;
    logic        w_held;
    logic [2:0]  aw_idx;
    logic [31:0] w_data;
    logic [3:0]  w_strb;
    logic        done;
    logic        tf_q;
    logic        tf_rise;
    logic        wr_fire;
    logic        wr_ok;
    logic        host_byte0_reg0;
    logic [31:0] status;
    logic [31:0] rd_data;
    logic [1:0]  rd_resp;
    logic        unused_addr_bits;
`ifdef CTRL_IRQ_EN
    logic        irq_mask;
`endif

    assign unused_addr_bits = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};

    assign slave_lite_reg0 = regs[0];
    assign slave_lite_reg1 = regs[1];
    assign slave_lite_reg2 = regs[2];
    assign slave_lite_reg3 = regs[3];

    assign tf_rise         = task_finish & ~tf_q;
    assign wr_fire         = aw_held & w_held & ~s_axi_bvalid;
    assign host_byte0_reg0 = wr_fire && (aw_idx == 3'd0) && w_strb[0];
    assign status          = {18'b0, state, 6'b0, done, ~state[0]};

    always_comb begin
        wr_ok = 1'b0;
        case (aw_idx)
            3'd0, 3'd1, 3'd2, 3'd3, 3'd4: wr_ok = 1'b1;
`ifdef CTRL_IRQ_EN
            3'd5:                         wr_ok = 1'b1;
`endif
            default:                      wr_ok = 1'b0;
        endcase
    end

    always_comb begin
        rd_data = 32'h0;
        rd_resp = RESP_OKAY;
        case (s_axi_araddr[4:2])
            3'd0:    rd_data = regs[0];
            3'd1:    rd_data = regs[1];
            3'd2:    rd_data = regs[2];
            3'd3:    rd_data = regs[3];
            3'd4:    rd_data = status;
`ifdef CTRL_IRQ_EN
            3'd5:    rd_data = {31'b0, irq_mask};
`endif
            default: rd_resp = RESP_SLVERR;
        endcase
    end

    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b0;
            s_axi_bvalid  <= 1'b0;
            s_axi_bresp   <= RESP_OKAY;
            aw_held       <= 1'b0;
            w_held        <= 1'b0;
            aw_idx        <= 3'd0;
            w_data        <= 32'h0;
            w_strb        <= 4'h0;
        end else if (s_axi_bvalid && s_axi_bready) begin
            s_axi_bvalid  <= 1'b0;
            aw_held       <= 1'b0;
            w_held        <= 1'b0;
            s_axi_awready <= 1'b1;
            s_axi_wready  <= 1'b1;
        end else begin
            if (s_axi_awvalid && s_axi_awready) begin
                aw_held       <= 1'b1;
                aw_idx        <= s_axi_awaddr[4:2];
                s_axi_awready <= 1'b0;
            end else if (!aw_held) begin
                s_axi_awready <= 1'b1;
            end
            if (s_axi_wvalid && s_axi_wready) begin
                w_held       <= 1'b1;
                w_data       <= s_axi_wdata;
                w_strb       <= s_axi_wstrb;
                s_axi_wready <= 1'b0;
            end else if (!w_held) begin
                s_axi_wready <= 1'b1;
            end
            if (wr_fire) begin
                s_axi_bvalid <= 1'b1;
                s_axi_bresp  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end

    // Auto-clear of the start bits yields to a host write of byte 0 on the same edge.
    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            for (int i = 0; i < 4; i++) regs[i] <= 32'h0;
            tf_q <= 1'b0;
            done <= 1'b0;
        end else begin
            tf_q <= task_finish;
            for (int i = 0; i < 4; i++) begin
                if (wr_fire && (aw_idx == 3'(i))) begin
                    for (int b = 0; b < 4; b++) begin
                        if (w_strb[b]) regs[i][8*b +: 8] <= w_data[8*b +: 8];
                    end
                end
            end
            if (tf_rise && !host_byte0_reg0) regs[0][3:0] <= 4'h0;
            if (tf_rise) begin
                done <= 1'b1;
            end else if (wr_fire && (aw_idx == 3'd4) && w_strb[0] && w_data[1]) begin
                done <= 1'b0;
            end
        end
    end

    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            s_axi_arready <= 1'b0;
            s_axi_rvalid  <= 1'b0;
            s_axi_rdata   <= 32'h0;
            s_axi_rresp   <= RESP_OKAY;
        end else if (s_axi_arvalid && s_axi_arready) begin
            s_axi_rvalid  <= 1'b1;
            s_axi_rdata   <= rd_data;
            s_axi_rresp   <= rd_resp;
            s_axi_arready <= 1'b0;
        end else if (s_axi_rvalid && s_axi_rready) begin
            s_axi_rvalid  <= 1'b0;
            s_axi_arready <= 1'b1;
        end else if (!s_axi_rvalid) begin
            s_axi_arready <= 1'b1;
        end
    end

`ifdef CTRL_IRQ_EN
    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            irq_mask <= 1'b0;
            irq      <= 1'b0;
        end else begin
            if (wr_fire && (aw_idx == 3'd5) && w_strb[0]) irq_mask <= w_data[0];
            irq <= done & irq_mask;
        end
    end
`endif

endmodule

// File: tb/tb_axi_lite_ctrl_regs.sv
// Self-checking bench for axi_lite_ctrl_regs: reference register model plus
// expected-response queues for the B and R channels.
module tb_axi_lite_ctrl_regs;

    logic        sclk;
    logic        s_rst_n;
    logic [4:0]  s_axi_awaddr;
    logic        s_axi_awvalid;
    logic        s_axi_awready;
    logic [31:0] s_axi_wdata;
    logic [3:0]  s_axi_wstrb;
    logic        s_axi_wvalid;
    logic        s_axi_wready;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_bvalid;
    logic        s_axi_bready;
    logic [4:0]  s_axi_araddr;
    logic        s_axi_arvalid;
    logic        s_axi_arready;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rvalid;
    logic        s_axi_rready;
    logic [31:0] slave_lite_reg0;
    logic [31:0] slave_lite_reg1;
    logic [31:0] slave_lite_reg2;
    logic [31:0] slave_lite_reg3;
    logic        task_finish;
    logic [5:0]  ctl_state;
`ifdef CTRL_IRQ_EN
    logic        irq;
`endif

    int checks;
    int errors;

    logic [31:0] m_reg [4];
    logic        m_done;
    logic        m_mask;

    logic [33:0] exp_q [$];
    logic [1:0]  bresp_q [$];

    axi_lite_ctrl_regs #(.ADDR_W(5)) dut (
        .sclk            (sclk),
        .s_rst_n         (s_rst_n),
        .s_axi_awaddr    (s_axi_awaddr),
        .s_axi_awvalid   (s_axi_awvalid),
        .s_axi_awready   (s_axi_awready),
        .s_axi_wdata     (s_axi_wdata),
        .s_axi_wstrb     (s_axi_wstrb),
        .s_axi_wvalid    (s_axi_wvalid),
        .s_axi_wready    (s_axi_wready),
        .s_axi_bresp     (s_axi_bresp),
        .s_axi_bvalid    (s_axi_bvalid),
        .s_axi_bready    (s_axi_bready),
        .s_axi_araddr    (s_axi_araddr),
        .s_axi_arvalid   (s_axi_arvalid),
        .s_axi_arready   (s_axi_arready),
        .s_axi_rdata     (s_axi_rdata),
        .s_axi_rresp     (s_axi_rresp),
        .s_axi_rvalid    (s_axi_rvalid),
        .s_axi_rready    (s_axi_rready),
        .slave_lite_reg0 (slave_lite_reg0),
        .slave_lite_reg1 (slave_lite_reg1),
        .slave_lite_reg2 (slave_lite_reg2),
        .slave_lite_reg3 (slave_lite_reg3),
        .task_finish     (task_finish),
        .state           (ctl_state)
`ifdef CTRL_IRQ_EN
        ,
        .irq             (irq)
`endif
    );

    // Clock / watchdog
    initial begin
        sclk = 1'b0;
        forever #5 sclk = ~sclk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Reference model
    function automatic logic [1:0] exp_bresp(input logic [4:0] a);
        if (a[4:2] <= 3'd4) return 2'b00;
`ifdef CTRL_IRQ_EN
        if (a[4:2] == 3'd5) return 2'b00;
`endif
        return 2'b10;
    endfunction

    function automatic logic [33:0] exp_read(input logic [4:0] a);
        case (a[4:2])
            3'd0, 3'd1, 3'd2, 3'd3: return {2'b00, m_reg[a[3:2]]};
            3'd4: return {2'b00, 18'b0, ctl_state, 6'b0, m_done, ~ctl_state[0]};
`ifdef CTRL_IRQ_EN
            3'd5: return {2'b00, 31'b0, m_mask};
`endif
            default: return {2'b10, 32'h0};
        endcase
    endfunction

    task automatic model_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
        if (a[4:2] < 3'd4) begin
            for (int b = 0; b < 4; b++) begin
                if (s[b]) m_reg[a[3:2]][8*b +: 8] = d[8*b +: 8];
            end
        end else if (a[4:2] == 3'd4) begin
            if (s[0] && d[1]) m_done = 1'b0;
        end
`ifdef CTRL_IRQ_EN
        else if (a[4:2] == 3'd5) begin
            if (s[0]) m_mask = d[0];
        end
`endif
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_reg[i] = 32'h0;
        m_done = 1'b0;
        m_mask = 1'b0;
    endtask

    // Driver tasks
    task automatic wait_b(output int lat);
        logic [1:0] exp_b;
        lat = 0;
        @(negedge sclk);
        while (!s_axi_bvalid && lat < 20) begin
            lat++;
            @(negedge sclk);
        end
        exp_b = bresp_q.pop_front();
        checks++;
        if (s_axi_bvalid !== 1'b1) begin
            errors++;
            $display("FAIL bvalid_timeout actual=%b required=1", s_axi_bvalid);
        end else if (s_axi_bresp !== exp_b) begin
            errors++;
            $display("FAIL bresp actual=%b required=%b", s_axi_bresp, exp_b);
        end
        s_axi_bready = 1'b1;
        @(posedge sclk);
        #1;
        s_axi_bready = 1'b0;
    endtask

    task automatic axi_write(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int aw_delay, output int lat);
        int   cyc;
        logic aw_done, w_done, aw_take, w_take;
        bresp_q.push_back(exp_bresp(addr));
        model_write(addr, data, strb);
        @(negedge sclk);
        s_axi_awaddr  = addr;
        s_axi_wdata   = data;
        s_axi_wstrb   = strb;
        s_axi_wvalid  = 1'b1;
        s_axi_awvalid = (aw_delay == 0);
        aw_done = 1'b0;
        w_done  = 1'b0;
        cyc     = 0;
        while (!(aw_done && w_done) && cyc < 20) begin
            aw_take = s_axi_awvalid && s_axi_awready;
            w_take  = s_axi_wvalid && s_axi_wready;
            @(posedge sclk);
            #1;
            if (aw_take) begin s_axi_awvalid = 1'b0; aw_done = 1'b1; end
            if (w_take)  begin s_axi_wvalid = 1'b0;  w_done = 1'b1;  end
            cyc++;
            if (!aw_done && !s_axi_awvalid && cyc >= aw_delay) s_axi_awvalid = 1'b1;
            if (!(aw_done && w_done)) @(negedge sclk);
        end
        checks++;
        if (!(aw_done && w_done)) begin
            errors++;
            $display("FAIL write_handshake addr=%h actual aw=%b w=%b required aw=1 w=1", addr, aw_done, w_done);
            s_axi_awvalid = 1'b0;
            s_axi_wvalid  = 1'b0;
        end
        wait_b(lat);
    endtask

    task automatic axi_read(input logic [4:0] addr, input int hold);
        int          cyc;
        logic [33:0] exp;
        exp_q.push_back(exp_read(addr));
        @(negedge sclk);
        s_axi_araddr  = addr;
        s_axi_arvalid = 1'b1;
        cyc = 0;
        while (!s_axi_arready && cyc < 20) begin
            cyc++;
            @(negedge sclk);
        end
        @(posedge sclk);
        #1;
        s_axi_arvalid = 1'b0;
        cyc = 0;
        @(negedge sclk);
        while (!s_axi_rvalid && cyc < 20) begin
            cyc++;
            @(negedge sclk);
        end
        exp = exp_q.pop_front();
        checks++;
        if (s_axi_rvalid !== 1'b1 || {s_axi_rresp, s_axi_rdata} !== exp) begin
            errors++;
            $display("FAIL read addr=%h actual rvalid=%b resp=%b data=%h required rvalid=1 resp=%b data=%h",
                     addr, s_axi_rvalid, s_axi_rresp, s_axi_rdata, exp[33:32], exp[31:0]);
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge sclk);
            checks++;
            if (s_axi_rvalid !== 1'b1 || s_axi_arready !== 1'b0 || {s_axi_rresp, s_axi_rdata} !== exp) begin
                errors++;
                $display("FAIL read_hold cycle=%0d actual rvalid=%b arready=%b resp=%b data=%h required 1 0 %b %h",
                         h, s_axi_rvalid, s_axi_arready, s_axi_rresp, s_axi_rdata, exp[33:32], exp[31:0]);
            end
        end
        s_axi_rready = 1'b1;
        @(posedge sclk);
        #1;
        s_axi_rready = 1'b0;
        @(negedge sclk);
        checks++;
        if (s_axi_rvalid !== 1'b0 || s_axi_arready !== 1'b1) begin
            errors++;
            $display("FAIL read_release actual rvalid=%b arready=%b required rvalid=0 arready=1",
                     s_axi_rvalid, s_axi_arready);
        end
    endtask

    task automatic check_regs(input string tag);
        logic [31:0] act [4];
        act[0] = slave_lite_reg0;
        act[1] = slave_lite_reg1;
        act[2] = slave_lite_reg2;
        act[3] = slave_lite_reg3;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (act[i] !== m_reg[i]) begin
                errors++;
                $display("FAIL %s reg%0d actual=%h required=%h", tag, i, act[i], m_reg[i]);
            end
        end
    endtask

    task automatic pulse_finish(input int n);
        @(negedge sclk);
        task_finish = 1'b1;
        ctl_state   = 6'b100000;
        m_reg[0][3:0] = 4'h0;
        m_done = 1'b1;
        repeat (n) @(negedge sclk);
        task_finish = 1'b0;
        ctl_state   = 6'b000001;
    endtask

    // Host write whose register-update edge coincides with a task_finish rising edge.
    task automatic write_at_finish(input logic [4:0] addr, input logic [31:0] data);
        int lat;
        bresp_q.push_back(exp_bresp(addr));
        model_write(addr, data, 4'hF);
        @(negedge sclk);
        checks++;
        if (s_axi_awready !== 1'b1 || s_axi_wready !== 1'b1) begin
            errors++;
            $display("FAIL collision_ready actual aw=%b w=%b required 1 1", s_axi_awready, s_axi_wready);
        end
        s_axi_awaddr  = addr;
        s_axi_wdata   = data;
        s_axi_wstrb   = 4'hF;
        s_axi_awvalid = 1'b1;
        s_axi_wvalid  = 1'b1;
        @(posedge sclk);
        #1;
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
        task_finish   = 1'b1;
        ctl_state     = 6'b100000;
        if (addr[4:2] != 3'd0) m_reg[0][3:0] = 4'h0;
        m_done = 1'b1;
        wait_b(lat);
        @(negedge sclk);
        task_finish = 1'b0;
        ctl_state   = 6'b000001;
    endtask

    // Tests
    task automatic test_reset();
        s_rst_n = 1'b0;
        repeat (3) @(negedge sclk);
        checks++;
        if ({s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_rvalid} !== 5'b0) begin
            errors++;
            $display("FAIL reset_handshake actual=%b required=00000",
                     {s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_rvalid});
        end
        checks++;
        if ({s_axi_bresp, s_axi_rresp, s_axi_rdata} !== 36'h0) begin
            errors++;
            $display("FAIL reset_resp actual bresp=%b rresp=%b rdata=%h required 0", s_axi_bresp, s_axi_rresp, s_axi_rdata);
        end
        check_regs("reset");
        s_rst_n = 1'b1;
        @(negedge sclk);
        checks++;
        if ({s_axi_awready, s_axi_wready, s_axi_arready} !== 3'b111) begin
            errors++;
            $display("FAIL ready_after_reset actual=%b required=111", {s_axi_awready, s_axi_wready, s_axi_arready});
        end
    endtask

    task automatic test_aw_w_same();
        int lat;
        axi_write(5'h04, 32'hA5A5_1234, 4'hF, 0, lat);
        checks++;
        if (lat !== 1) begin
            errors++;
            $display("FAIL b_latency actual=%0d required=1", lat);
        end
        check_regs("aw_w_same");
        axi_read(5'h04, 0);
    endtask

    task automatic test_w_before_aw();
        int lat;
        axi_write(5'h08, 32'h1122_3344, 4'hF, 0, lat);
        axi_write(5'h08, 32'h0000_7700, 4'b0010, 3, lat);
        check_regs("w_before_aw");
        axi_write(5'h0F, 32'hDEAD_BEEF, 4'hF, 1, lat);
        check_regs("low_addr_bits");
        axi_read(5'h0D, 0);
    endtask

    task automatic test_finish_clear();
        int lat;
        axi_write(5'h00, 32'hC0DE_0004, 4'hF, 0, lat);
        pulse_finish(3);
        @(negedge sclk);
        check_regs("finish_clear");
        axi_read(5'h10, 0);
        axi_write(5'h10, 32'h0000_0002, 4'hF, 0, lat);
        axi_read(5'h10, 0);
    endtask

    task automatic test_unmapped();
        int lat;
        axi_read(5'h18, 5);
        axi_read(5'h14, 0);
        axi_write(5'h18, 32'hFFFF_FFFF, 4'hF, 0, lat);
        axi_write(5'h1C, 32'h1234_5678, 4'hF, 0, lat);
        check_regs("unmapped_write");
    endtask

    task automatic test_collisions();
        write_at_finish(5'h00, 32'h0000_0001);
        check_regs("collision_reg0");
        axi_read(5'h10, 0);
        write_at_finish(5'h10, 32'h0000_0002);
        check_regs("collision_done");
        axi_read(5'h10, 0);
    endtask

    task automatic test_concurrent();
        int lat_c;
        fork
            axi_write(5'h04, 32'h0BAD_F00D, 4'hF, 0, lat_c);
            axi_read(5'h0C, 0);
        join
        check_regs("concurrent");
    endtask

`ifdef CTRL_IRQ_EN
    task automatic test_irq();
        int lat;
        axi_write(5'h14, 32'h0000_0001, 4'hF, 0, lat);
        axi_read(5'h14, 0);
        pulse_finish(3);
        @(negedge sclk);
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL irq_set actual=%b required=1", irq);
        end
        axi_write(5'h10, 32'h0000_0002, 4'hF, 0, lat);
        @(negedge sclk);
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL irq_clear actual=%b required=0", irq);
        end
    endtask
`endif

    task automatic test_random();
        int          lat;
        logic [4:0]  a;
        logic [31:0] d;
        logic [3:0]  s;
        for (int n = 0; n < 12; n++) begin
            a = 5'($urandom_range(0, 31));
            d = $urandom;
            s = 4'($urandom_range(0, 15));
            axi_write(a, d, s, $urandom_range(0, 3), lat);
            axi_read(a, $urandom_range(0, 2));
        end
        check_regs("random");
    endtask

    task automatic test_reset_mid();
        @(negedge sclk);
        s_axi_awaddr  = 5'h08;
        s_axi_wdata   = 32'h5555_AAAA;
        s_axi_wstrb   = 4'hF;
        s_axi_awvalid = 1'b1;
        s_axi_wvalid  = 1'b1;
        @(posedge sclk);
        #1;
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
        s_rst_n       = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({s_axi_awready, s_axi_wready, s_axi_bvalid} !== 3'b000) begin
            errors++;
            $display("FAIL reset_mid_async actual=%b required=000", {s_axi_awready, s_axi_wready, s_axi_bvalid});
        end
        check_regs("reset_mid");
        repeat (2) @(negedge sclk);
        s_rst_n = 1'b1;
        repeat (2) @(negedge sclk);
        checks++;
        if (s_axi_bvalid !== 1'b0 || {s_axi_awready, s_axi_wready} !== 2'b11) begin
            errors++;
            $display("FAIL reset_mid_no_resp actual bvalid=%b ready=%b required bvalid=0 ready=11",
                     s_axi_bvalid, {s_axi_awready, s_axi_wready});
        end
        check_regs("reset_mid_after");
        axi_read(5'h10, 0);
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        s_rst_n       = 1'b0;
        s_axi_awaddr  = 5'h0;
        s_axi_awvalid = 1'b0;
        s_axi_wdata   = 32'h0;
        s_axi_wstrb   = 4'h0;
        s_axi_wvalid  = 1'b0;
        s_axi_bready  = 1'b0;
        s_axi_araddr  = 5'h0;
        s_axi_arvalid = 1'b0;
        s_axi_rready  = 1'b0;
        task_finish   = 1'b0;
        ctl_state     = 6'b000001;
        model_reset();

        test_reset();
        test_aw_w_same();
        test_w_before_aw();
        test_finish_clear();
        test_unmapped();
        test_collisions();
        test_concurrent();
`ifdef CTRL_IRQ_EN
        test_irq();
`endif
        test_random();
        test_reset_mid();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
